// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared types for the hazard/forwarding controller: mux select codes, shadow-entry layouts.
// Pure definitions; no latency or backpressure of its own.
package hazard_forward_ctrl_pkg;

    localparam int REG_AW = 5;

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_WB  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic              memread;
    } shadow_t;

    // Producer view of a stage: the fields a forwarding comparison looks at.
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
    } prod_t;

    function automatic prod_t to_prod(input shadow_t e);
        prod_t p;
        p.valid    = e.valid;
        p.rd       = e.rd;
        p.regwrite = e.regwrite;
        return p;
    endfunction

endpackage

// File: rtl/hazard_forward_ctrl_fwd_match.sv
// Producer-match comparator: does this stage write a nonzero register equal to the source?
// Purely combinational; no backpressure.
module fwd_match
    import hazard_forward_ctrl_pkg::*;
(
    input  prod_t             i_entry,
    input  logic [REG_AW-1:0] i_src,
    output logic              o_match
);

    assign o_match = i_entry.valid & i_entry.regwrite &
                     (i_entry.rd != '0) & (i_entry.rd == i_src);

endmodule

// File: rtl/hazard_forward_ctrl.sv
// EX-stage operand forwarding selects (1-cycle, registered) and load-use stall (0-cycle, combinational).
// Stall holds PC/IF-ID; flush overrides stall and drops the ID instruction.
module hazard_forward_ctrl #(
    parameter int REG_AW = hazard_forward_ctrl_pkg::REG_AW
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic              id_uses_rt_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_regwrite_i,
    input  logic              id_memread_i,
    input  logic              flush_i,
    output logic              stall_o,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o,
    output logic              ex_bubble_o
);
    import hazard_forward_ctrl_pkg::*;

    // No WB shadow is kept: the register file writes before it is read, so
    // nothing past MEM is ever compared.
    shadow_t r_ex;
    prod_t   r_mem;

    shadow_t    w_id_entry;
    logic       w_ex_rs, w_ex_rt, w_mem_rs, w_mem_rt;
    logic       w_load_use;
    logic       w_insert_bubble;
    logic [1:0] w_sel_a, w_sel_b;

    always_comb begin
        w_id_entry          = '0;
        w_id_entry.valid    = 1'b1;
        w_id_entry.rd       = id_rd_i;
        w_id_entry.regwrite = id_regwrite_i;
        w_id_entry.memread  = id_memread_i;
    end

    fwd_match u_ex_rs  (.i_entry(to_prod(r_ex)), .i_src(id_rs_i), .o_match(w_ex_rs));
    fwd_match u_ex_rt  (.i_entry(to_prod(r_ex)), .i_src(id_rt_i), .o_match(w_ex_rt));
    fwd_match u_mem_rs (.i_entry(r_mem),         .i_src(id_rs_i), .o_match(w_mem_rs));
    fwd_match u_mem_rt (.i_entry(r_mem),         .i_src(id_rt_i), .o_match(w_mem_rt));

    assign w_load_use = r_ex.memread & (w_ex_rs | (id_uses_rt_i & w_ex_rt));
    assign stall_o    = w_load_use & id_valid_i & ~flush_i;

    assign w_insert_bubble = stall_o | flush_i | ~id_valid_i;

    // Newest producer wins: EX/MEM result before MEM/WB result.
    always_comb begin
        w_sel_a = SEL_RF;
        if (w_ex_rs)
            w_sel_a = SEL_MEM;
        else if (w_mem_rs)
            w_sel_a = SEL_WB;

        w_sel_b = SEL_RF;
        if (id_uses_rt_i) begin
            if (w_ex_rt)
                w_sel_b = SEL_MEM;
            else if (w_mem_rt)
                w_sel_b = SEL_WB;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ex        <= '0;
            r_mem       <= '0;
            fwd_a_o     <= SEL_RF;
            fwd_b_o     <= SEL_RF;
            ex_bubble_o <= 1'b1;
        end else begin
            r_mem       <= to_prod(r_ex);
            ex_bubble_o <= w_insert_bubble;
            if (w_insert_bubble) begin
                r_ex    <= '0;
                fwd_a_o <= SEL_RF;
                fwd_b_o <= SEL_RF;
            end else begin
                r_ex    <= w_id_entry;
                fwd_a_o <= w_sel_a;
                fwd_b_o <= w_sel_b;
            end
        end
    end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed bench for hazard_forward_ctrl: short MIPS-like sequences with hand-computed selects.
module tb_hazard_forward_ctrl;

    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          id_valid_i;
    logic [AW-1:0] id_rs_i, id_rt_i, id_rd_i;
    logic          id_uses_rt_i, id_regwrite_i, id_memread_i;
    logic          flush_i;
    logic          stall_o;
    logic [1:0]    fwd_a_o, fwd_b_o;
    logic          ex_bubble_o;

    int n_cmp = 0;
    int n_err = 0;

    hazard_forward_ctrl #(.REG_AW(AW)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .id_valid_i   (id_valid_i),
        .id_rs_i      (id_rs_i),
        .id_rt_i      (id_rt_i),
        .id_uses_rt_i (id_uses_rt_i),
        .id_rd_i      (id_rd_i),
        .id_regwrite_i(id_regwrite_i),
        .id_memread_i (id_memread_i),
        .flush_i      (flush_i),
        .stall_o      (stall_o),
        .fwd_a_o      (fwd_a_o),
        .fwd_b_o      (fwd_b_o),
        .ex_bubble_o  (ex_bubble_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic id(input logic v, input int rs, input int rt, input logic ur,
                      input int rd, input logic rw, input logic mr);
        id_valid_i    = v;
        id_rs_i       = AW'(rs);
        id_rt_i       = AW'(rt);
        id_uses_rt_i  = ur;
        id_rd_i       = AW'(rd);
        id_regwrite_i = rw;
        id_memread_i  = mr;
    endtask

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk_ex(input string tag, input logic [1:0] fa, input logic [1:0] fb,
                          input logic bub);
        chk({tag, "_fwd_a"}, fwd_a_o, fa);
        chk({tag, "_fwd_b"}, fwd_b_o, fb);
        chk({tag, "_bubble"}, {1'b0, ex_bubble_o}, {1'b0, bub});
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i   = 1'b1;
        flush_i = 1'b0;
        id(0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        rst_i = 1'b0;
        #1;
        chk_ex("reset", 2'b00, 2'b00, 1'b1);
        chk("reset_stall", {1'b0, stall_o}, 2'b00);

        // add $3,$1,$2 ; sub $4,$3,$5
        id(1, 1, 2, 1, 3, 1, 0);
        #1 chk("s1_add_stall", {1'b0, stall_o}, 2'b00);
        tick();
        id(1, 3, 5, 1, 4, 1, 0);
        #1 chk("s1_sub_stall", {1'b0, stall_o}, 2'b00);
        tick();
        chk_ex("s1_sub", 2'b10, 2'b00, 1'b0);

        // add $3,$1,$2 ; nop ; or $6,$1,$3
        id(1, 1, 2, 1, 3, 1, 0);
        tick();
        id(0, 0, 0, 0, 0, 0, 0);
        tick();
        chk_ex("s2_nop", 2'b00, 2'b00, 1'b1);
        id(1, 1, 3, 1, 6, 1, 0);
        tick();
        chk_ex("s2_or", 2'b00, 2'b01, 1'b0);

        // lw $2,0($1) ; add $4,$2,$2
        id(1, 1, 2, 0, 2, 1, 1);
        tick();
        id(1, 2, 2, 1, 4, 1, 0);
        #1 chk("s3_stall_on", {1'b0, stall_o}, 2'b01);
        tick();
        chk_ex("s3_bubble", 2'b00, 2'b00, 1'b1);
        chk("s3_stall_off", {1'b0, stall_o}, 2'b00);
        tick();
        chk_ex("s3_add", 2'b01, 2'b01, 1'b0);

        // add $0,$1,$1 ; add $5,$0,$0
        id(1, 1, 1, 1, 0, 1, 0);
        tick();
        id(1, 0, 0, 1, 5, 1, 0);
        #1 chk("s4_stall", {1'b0, stall_o}, 2'b00);
        tick();
        chk_ex("s4_r0", 2'b00, 2'b00, 1'b0);

        // add $3 ; add $3 ; sub $7,$3,$3
        id(1, 1, 1, 1, 3, 1, 0);
        tick();
        id(1, 2, 2, 1, 3, 1, 0);
        tick();
        id(1, 3, 3, 1, 7, 1, 0);
        tick();
        chk_ex("s5_prio", 2'b10, 2'b10, 1'b0);

        // lw $2 ; add $4,$2,$2 with flush on the would-be stall cycle
        id(1, 1, 2, 0, 2, 1, 1);
        tick();
        id(1, 2, 2, 1, 4, 1, 0);
        flush_i = 1'b1;
        #1 chk("s6_flush_stall", {1'b0, stall_o}, 2'b00);
        tick();
        flush_i = 1'b0;
        chk_ex("s6_flush", 2'b00, 2'b00, 1'b1);
        // the load still advanced into MEM
        id(1, 2, 1, 1, 8, 1, 0);
        #1 chk("s6_next_stall", {1'b0, stall_o}, 2'b00);
        tick();
        chk_ex("s6_next", 2'b01, 2'b00, 1'b0);

        // rs == rt == $8 but rt not read: only operand A forwards
        id(1, 8, 8, 0, 9, 1, 0);
        tick();
        chk_ex("s7_no_rt", 2'b10, 2'b00, 1'b0);

        // reset mid-stream discards the in-flight add $3
        id(1, 1, 2, 1, 3, 1, 0);
        tick();
        id(1, 3, 3, 1, 4, 1, 0);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        #1;
        chk_ex("s8_reset", 2'b00, 2'b00, 1'b1);
        chk("s8_reset_stall", {1'b0, stall_o}, 2'b00);
        tick();
        chk_ex("s8_after", 2'b00, 2'b00, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
